// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared widths, reset PC, NOP encoding and IF/ID record for the ARM-subset pipeline
package arm_pipe_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic                   valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; en gates everything, flush clears, hold freezes, else loads
module ifid_reg
  import arm_pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               hold,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               keep;

  assign keep = !en || (!flush && hold);

  always_comb begin
    pc_d    = keep ? pc_q    : flush ? '0 : pc_in;
    instr_d = keep ? instr_q : flush ? INSTR_W'(NOP_INSTR) : instr_in;
    valid_d = keep ? valid_q : !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, addresses instruction memory and feeds the IF/ID register
module fetch_stage
  import arm_pipe_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int              INSTR_W  = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               flush,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic [31:0]        fetch_count
);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              load;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign load     = !stall && !flush && !freeze;

  // a taken branch wins over freeze since the frozen ID instruction is squashed
  always_comb begin
    pc_d          = stall ? pc_q
                  : branch_taken ? (branch_addr & ~ADDR_W'(3))
                  : freeze ? pc_q : pc_plus4;
    fetch_count_d = load ? fetch_count_q + 32'd1 : fetch_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifid_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .en       (!stall),
    .flush    (flush),
    .hold     (freeze),
    .pc_in    (pc_plus4),
    .instr_in (imem_data),
    .pc       (ifid_pc),
    .instr    (ifid_instr),
    .valid    (ifid_valid)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps against a reference model with an IF/ID scoreboard queue
module tb_fetch_stage;
  import arm_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, freeze = 1'b0, branch_taken = 1'b0, flush = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr, imem_data, pc, ifid_pc, ifid_instr, fetch_count;
  logic        ifid_valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  ifid_t       m_ifid = '0;
  ifid_t       sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hE000_0000 ^ {a[31:2], 2'b00} ^ {a[9:2], 24'h0};
  endfunction

  assign imem_data = memw(imem_addr);

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .flush        (flush),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc           (pc),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count)
  );

  // a taken branch without flush lets a wrong-path word into IF/ID
  always @(posedge clk)
    if (!rst && !stall) assert (!(branch_taken && !flush)) else begin
      errors++;
      $error("FAIL misconnect: branch_taken=1 with flush=0");
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic fr,
                      input logic bt, input logic fl, input logic [31:0] ba);
    ifid_t e;
    rst = r; stall = st; freeze = fr; branch_taken = bt; flush = fl; branch_addr = ba;
    if (r) begin
      m_pc = 32'h0; m_ifid = '0; m_cnt = '0;
    end else if (!st) begin
      if (fl) m_ifid = '0;
      else if (!fr) begin
        m_ifid = '{pc: m_pc + 32'd4, instr: memw(m_pc), valid: 1'b1};
        m_cnt++;
      end
      m_pc = bt ? {ba[31:2], 2'b00} : fr ? m_pc : m_pc + 32'd4;
    end
    sb.push_back(m_ifid);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_pc", ifid_pc, e.pc);
    chk("ifid_instr", ifid_instr, e.instr);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 1, 32'h40);
    chk("reset_valid", {31'b0, ifid_valid}, 32'd0);
    run(2);
    chk("pc_at_8", pc, 32'h8);
    chk("ifid_w1", ifid_instr, memw(32'h4));
    step(0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);
    chk("freeze_pc", pc, 32'h8);
    chk("freeze_ifid_pc", ifid_pc, 32'h8);
    chk("freeze_cnt", fetch_count, 32'd2);
    run(1);
    chk("release_pc", pc, 32'hC);
    run(1);
    chk("pc_at_16", pc, 32'h10);
    step(0, 0, 0, 1, 1, 32'h0000_0093);
    chk("br_pc", pc, 32'h90);
    chk("br_valid", {31'b0, ifid_valid}, 32'd0);
    run(1);
    chk("br_target_instr", ifid_instr, memw(32'h90));
    chk("br_target_ifid_pc", ifid_pc, 32'h94);
    run(1);
    step(0, 0, 1, 1, 1, 32'h0000_0200);
    chk("br_freeze_pc", pc, 32'h200);
    chk("br_freeze_valid", {31'b0, ifid_valid}, 32'd0);
    run(2);
    step(0, 1, 0, 0, 0, 32'h0);
    step(0, 1, 0, 1, 1, 32'h0000_0500);
    step(0, 1, 0, 0, 0, 32'h0);
    chk("stall_pc", pc, 32'h208);
    run(1);
    chk("post_stall_pc", pc, 32'h20C);
    step(0, 0, 0, 0, 1, 32'h0);
    chk("flush_only_pc", pc, 32'h210);
    step(0, 0, 0, 1, 1, 32'h0000_0028);
    step(0, 0, 1, 0, 0, 32'h0);
    chk("pc_at_40", pc, 32'h28);
    step(1, 0, 1, 0, 0, 32'h0);
    chk("rst_freeze_pc", pc, 32'h0);
    chk("rst_freeze_cnt", fetch_count, 32'd0);
    run(1);
    chk("first_fetch", ifid_instr, memw(32'h0));
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    chk("force_fffc", pc, 32'hFFFF_FFFC);
    run(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_ifid_pc", ifid_pc, 32'h0);
    run(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage ARM-subset pipeline; sits directly upstream of the ID stage.
- Owns the program counter and addresses the combinational instruction memory (byte address in, word out; the memory indexes by address>>2).
- Registers the fetched word and PC+4 into the IF/ID pipeline register.
- Handles branch redirect from EXE, hazard freeze from the hazard unit, pipeline-wide stall from the SRAM controller, and flush.

Parameters:
- ADDR_W, 32, PC and instruction-address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTR_W, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  global stall from SRAM controller; holds all state, including branch redirect.
- freeze  in  1  hazard-unit freeze; holds PC and IF/ID.
- branch_taken  in  1  EXE-stage branch resolved taken.
- branch_addr  in  ADDR_W  branch target byte address; low 2 bits are ignored and forced to 0.
- flush  in  1  clear the IF/ID register (normally tied to branch_taken).
- imem_addr  out  ADDR_W  byte address to instruction memory; equals pc.
- imem_data  in  INSTR_W  instruction word returned combinationally for imem_addr.
- pc  out  ADDR_W  current fetch PC.
- ifid_pc  out  ADDR_W  registered PC+4 of the instruction held in IF/ID.
- ifid_instr  out  INSTR_W  registered instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset; wraps.

Behaviour:
- Reset (rst=1 at edge), which overrides every other input:
  - pc=RESET_PC; ifid_pc=0; ifid_instr=0; ifid_valid=0; fetch_count=0.
- Signals:
  - pc_plus4 = pc + 4, modulo 2^ADDR_W.
  - Wrap from 32'hFFFF_FFFC to 0 is legal and carries no special handling.
  - imem_addr = pc combinationally, with zero latency.
- Priority per edge, when rst=0:
  1. stall=1: pc, IF/ID and fetch_count all hold. branch_taken and flush are ignored; upstream holds them until stall drops.
  2. branch_taken=1: pc <= {branch_addr[ADDR_W-1:2],2'b00}. This applies even when freeze=1, because the frozen ID instruction is squashed.
  3. freeze=1: pc holds.
  4. Otherwise: pc <= pc_plus4.
- IF/ID update, when rst=0 and stall=0:
  - If flush=1: ifid_instr <= 0, ifid_valid <= 0, ifid_pc <= 0. Flush beats freeze.
  - Else if freeze=1: IF/ID holds.
  - Else: ifid_instr <= imem_data, ifid_pc <= pc_plus4, ifid_valid <= 1, and fetch_count increments.
- Latency: an instruction at address A appears on ifid_instr in the cycle after pc==A. The branch target is fetched in the cycle after branch_taken.
- flush without branch_taken is legal: IF/ID clears and pc advances or holds per the rules above.
- When branch_taken=1 and flush=0 (a misconnection), pc still redirects and IF/ID loads the wrong-path word. This case is not masked; the bench flags it with an assertion.
- Reset asserted mid-stall or mid-freeze: reset wins on that edge. The first fetch after reset is from RESET_PC.
- No X propagation: every register has a defined reset value, and imem_data is sampled only on a load.

Decomposition:
- Shared package `arm_pipe_pkg`:
  - ADDR_W, INSTR_W and RESET_PC defaults.
  - NOP_INSTR constant (32'h0).
  - Typedef `ifid_t` struct {pc, instr, valid}.
- One sub-module: `ifid_reg`, the IF/ID pipeline register with ld/flush/hold.
- The PC register and next-PC mux stay in fetch_stage.
- Instruction memory remains external.

Test Plan:
- Reset then free-run 4 cycles with imem returning words W0..W3:
  - pc steps 0,4,8,12.
  - ifid_instr = W0,W1,W2 on cycles 1..3.
  - ifid_pc = 4,8,12.
  - fetch_count=3.
- Freeze for 2 cycles at pc=8: pc stays 8, IF/ID holds W1 with ifid_pc=8, fetch_count is unchanged; after release, pc=12 next.
- branch_taken+flush with branch_addr=32'h0000_0093 at pc=16:
  - Next edge: pc=32'h90, ifid_valid=0, ifid_instr=0.
  - The edge after: ifid_instr=mem[0x90>>2], ifid_pc=32'h94.
- branch_taken+flush with freeze=1 together: pc takes the target and IF/ID flushes (valid=0).
- stall=1 for 3 cycles with branch_taken pulsed in the middle: pc, IF/ID and fetch_count are all unchanged and the branch is ignored; after stall drops, pc=pc+4.
- rst asserted during freeze at pc=40: pc=0, IF/ID cleared, fetch_count=0. pc_plus4 wrap from 32'hFFFF_FFFC (forced via branch_addr) gives pc=0 on the next edge.
